// File: rtl/config_pkg.sv
// config_pkg
// Shared definitions for the configuration loader:
//   - cfg_state_t: loader FSM state encoding (also visible on the loader's
//     fsm_state debug port)
//   - CRC-16-CCITT polynomial / init constants and a one-bit update helper
//   - CONFIG_LOADER_CHAIN_LEN: default chain length, equal to the fabric's
//     total configuration chain length
package config_pkg;

  localparam int CONFIG_LOADER_CHAIN_LEN = 1024;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } cfg_state_t;

  // One MSB-first CRC-16 step for a single serial bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = crc[15] ^ bit_in;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// crc16_serial
// Bit-serial CRC-16-CCITT accumulator (poly 0x1021, init 0xFFFF, MSB first).
// Only built when CONFIG_LOADER_CRC_EN is defined; the default build has no
// CRC logic at all, so the module body is compiled out as well.
// Ports:
//   clk, rst  clock, asynchronous active-high reset (crc -> init)
//   clear     reload crc with the init value
//   en        fold bit_in into the crc this cycle
//   bit_in    serial data bit
//   crc       current CRC value
`ifdef CONFIG_LOADER_CRC_EN
module crc16_serial
  import config_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC16_INIT;
    end else if (clear) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= crc16_step(crc, bit_in);
    end
  end

endmodule
`endif

// File: rtl/config_loader.sv
// config_loader
// Serialises configuration words onto the fabric's single-bit config chain,
// one bit per clock, MSB of each word first. CHAIN_LEN bits are shifted in
// total; if CHAIN_LEN is not a multiple of WORD_WIDTH only the top bits of
// the final word are used.
//
// Optional feature macro: CONFIG_LOADER_CRC_EN. When defined, a CRC-16-CCITT
// is accumulated over every shifted bit and one extra trailer word is taken
// after the chain; its low 16 bits are compared with the CRC and a mismatch
// raises error in DONE. Without the macro error is tied low and no trailer
// word is consumed.
//
// Handshake: a word transfers on a rising edge where word_valid and
// word_ready are both high. word_ready depends only on the state register,
// never on word_valid; word_valid seen while word_ready is low is ignored
// and nothing is consumed.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       one-cycle pulse; starts a load from IDLE or DONE
//   word_data   configuration word, word_valid qualifies it
//   word_ready  loader accepts a word this cycle (FETCH / CHECK)
//   config_out  serial bit to fabric config_in
//   config_en   fabric shift enable, high only while a real bit is driven
//   busy        load in progress
//   done        load complete, held until next start or rst
//   error       trailer CRC mismatch, held with done
//   fsm_state   current FSM state (debug)
module config_loader
  import config_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int CHAIN_LEN  = CONFIG_LOADER_CHAIN_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            fsm_state
);

  localparam int BL_W = $clog2(CHAIN_LEN + 1);
  localparam int SC_W = $clog2(WORD_WIDTH + 1);

  cfg_state_t            state;
  logic [WORD_WIDTH-1:0] shreg;
  logic [BL_W-1:0]       bits_left;
  logic [SC_W-1:0]       shift_cnt;
  logic                  start_ok;

  // A start is only honoured when no load is running.
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef CONFIG_LOADER_CRC_EN
  logic [15:0] crc;
  logic        err_q;

  crc16_serial u_crc (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_ok),
    .en     (state == ST_SHIFT),
    .bit_in (shreg[WORD_WIDTH-1]),
    .crc    (crc)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bits_left <= '0;
      shift_cnt <= '0;
`ifdef CONFIG_LOADER_CRC_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state     <= ST_FETCH;
            bits_left <= BL_W'(CHAIN_LEN);
`ifdef CONFIG_LOADER_CRC_EN
            err_q     <= 1'b0;
`endif
          end
        end
        ST_FETCH: begin
          if (word_valid) begin
            shreg <= word_data;
            // Compare at 32 bits: WORD_WIDTH may not fit in bits_left's width.
            if (32'(bits_left) >= WORD_WIDTH) begin
              shift_cnt <= SC_W'(WORD_WIDTH);
            end else begin
              shift_cnt <= SC_W'(bits_left);
            end
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg     <= shreg << 1;
          shift_cnt <= shift_cnt - SC_W'(1);
          bits_left <= bits_left - BL_W'(1);
          if (shift_cnt == SC_W'(1)) begin
            if (bits_left > BL_W'(1)) begin
              state <= ST_FETCH;
            end else begin
`ifdef CONFIG_LOADER_CRC_EN
              state <= ST_CHECK;
`else
              state <= ST_DONE;
`endif
            end
          end
        end
`ifdef CONFIG_LOADER_CRC_EN
        ST_CHECK: begin
          if (word_valid) begin
            err_q <= (word_data[15:0] != crc);
            state <= ST_DONE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  // All outputs decode registered state only.
  assign word_ready = (state == ST_FETCH) || (state == ST_CHECK);
  assign config_en  = (state == ST_SHIFT);
  assign config_out = config_en & shreg[WORD_WIDTH-1];
  assign busy       = (state == ST_FETCH) || (state == ST_SHIFT) || (state == ST_CHECK);
  assign done       = (state == ST_DONE);
`ifdef CONFIG_LOADER_CRC_EN
  assign error      = done & err_q;
`else
  assign error      = 1'b0;
`endif
  assign fsm_state  = state;

endmodule

// File: doc/config_loader.md
# config_loader

Serializes a configuration bitstream, supplied as parallel words over a valid/ready stream, onto the fabric's single-bit `config_in` chain. It is the transmitting end of the fabric configuration interface: sits between the off-fabric word source (host/scan bridge) and `fpga_250`'s `config_in`, drives the chain enable, and reports completion. One bit is shifted per clock, MSB of each word first.

## Interface
- `WORD_WIDTH`, 32: bits per input word.
- `CHAIN_LEN`, 1024: total configuration bits in the fabric chain (≥1).
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a load when in IDLE or DONE.
- `word_data`  in  WORD_WIDTH  configuration word.
- `word_valid`  in  1  `word_data` valid.
- `word_ready`  out  1  loader accepts a word this cycle.
- `config_out`  out  1  serial bit, connects to fabric `config_in`.
- `config_en`  out  1  fabric shift enable; high exactly in cycles where `config_out` is a real bit.
- `busy`  out  1  load in progress.
- `done`  out  1  load complete; held until next `start` or `rst`.
- `error`  out  1  checksum mismatch (see Configuration); held with `done`.

## Operation
- States: IDLE, FETCH, SHIFT, CHECK (macro only), DONE.
- IDLE: all outputs 0. `start` → FETCH; `bits_left` ← CHAIN_LEN.
- FETCH: `word_ready`=1, `busy`=1. On `word_valid & word_ready`: capture word into shift register, `shift_cnt` ← min(WORD_WIDTH, bits_left), → SHIFT. No valid → stay, no timeout.
- SHIFT: `config_en`=1, `config_out`=shreg MSB; each cycle shift left, decrement `shift_cnt` and `bits_left`. When `shift_cnt` reaches 1: `bits_left`>1 → FETCH; else → CHECK (macro) or DONE.
- Partial last word: when CHAIN_LEN mod WORD_WIDTH ≠ 0, only the top `bits_left` MSBs of the final word are shifted; low bits discarded.
- DONE: `done`=1, `busy`=0, `error` as computed. `start` → FETCH (fresh load, `done`/`error` clear same edge).
- `start` while busy (FETCH/SHIFT/CHECK): ignored.
- `word_valid` outside FETCH: ignored, not consumed.
- Counters: `bits_left` width $clog2(CHAIN_LEN+1); `shift_cnt` width $clog2(WORD_WIDTH+1); no wrap possible by construction.

## Timing
- Reset values: `word_ready`, `config_out`, `config_en`, `busy`, `done`, `error` all 0; state IDLE. Reset mid-load drops `config_en` asynchronously; partial fabric config is not recovered.
- All outputs registered or decoded from state register only; no input-to-output combinational path.
- `start` at edge N → `word_ready`=1 in cycle N+1.
- Handshake at edge M → first bit on `config_out` with `config_en`=1 in cycle M+1.
- Full word: WORD_WIDTH consecutive `config_en` cycles, then one FETCH cycle (≥1 bubble per word). Minimum load latency with valid held: CHAIN_LEN + ceil(CHAIN_LEN/WORD_WIDTH) + 1 cycles from `start` to `done`.
- `done` rises the cycle after the last shifted bit (or after CHECK with macro).

## Configuration
- `CONFIG_LOADER_CRC_EN` defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) updated on every shifted bit. After the last chain bit, state CHECK asserts `word_ready` and consumes one extra word; its low 16 bits are compared with the CRC. Mismatch → `error`=1 in DONE. Trailer bits never drive `config_en`.
- Undefined: no CRC logic, no CHECK state, `error` tied 0, no trailer word.

## Structure
- Package `config_pkg`: state enum `cfg_state_t`, CRC polynomial/init constants, default `CONFIG_LOADER_CHAIN_LEN` matching the fabric's total chain length.
- One sub-module: `crc16_serial` (1-bit update, clear, enable), instantiated only under the macro.

## Test plan
- CHAIN_LEN=40, WORD_WIDTH=16, words 0xA5C3, 0x0FF0, 0x81xx with valid always high → 40 `config_en` cycles, serial stream A5C3 0FF0 81 MSB-first, low byte of 3rd word dropped, `done` at cycle 44 after `start`.
- Same config, `word_valid` deasserted 5 cycles before 2nd word → loader waits in FETCH with `config_en`=0, stream unchanged, `done` 5 cycles later.
- `start` pulsed during SHIFT → no effect on stream or counters; `start` in DONE → `done` clears, new load begins.
- `rst` asserted mid-SHIFT (bit 20) → all outputs 0 immediately, IDLE; subsequent `start` performs full clean load.
- Macro on, correct CRC trailer → `done`=1, `error`=0; trailer with one bit flipped → `done`=1, `error`=1; trailer never raises `config_en`.
- CHAIN_LEN=16, WORD_WIDTH=16 (exact fit) and CHAIN_LEN=1 → one word, 16 resp. 1 `config_en` cycles, no extra FETCH.
